// File: rtl/clk_div_mon_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_mon_pkg
// Shared definitions for the divided-clock monitor: default divide ratios
// of the freq_div outputs, the measurement counter width, the number of
// consecutive good periods needed for lock, and the per-channel checker
// state encoding.
// ---------------------------------------------------------------------------
package clk_div_mon_pkg;

   // Expected periods of the freq_div outputs, in CLK_in cycles
   localparam int DIV_50_DEF   = 2;
   localparam int DIV_10_DEF   = 10;
   localparam int DIV_1_DEF    = 100;

   // Measurement counter width; every divide ratio must stay below 2**CNT_W-1
   localparam int CNT_W_DEF    = 8;

   // Consecutive good periods required before a channel reports lock
   localparam int LOCK_CNT_DEF = 4;

   // IDLE waits for the arming rise, MEAS counts between rising edges
   typedef enum logic {
      IDLE = 1'b0,
      MEAS = 1'b1
   } chk_state_t;

endpackage

// File: rtl/clk_period_chk.sv
// ---------------------------------------------------------------------------
// clk_period_chk
// Measures the period and high time of one monitored clock that is already
// a flop output in the CLK_in domain, and compares them against DIV and
// DIV/2. Reports the last measured period, a one-cycle update strobe, a
// lock flag after LOCK_CNT consecutive good periods, and a sticky error.
// Ports:
//   clk_in      reference clock
//   rst_n       asynchronous active-low reset
//   mon_clk     monitored clock (synchronous to clk_in)
//   clr_err     clears the sticky error (a same-cycle new error wins)
//   period      last measured period (all-ones on a stuck clock)
//   meas_valid  one-cycle pulse when period is updated
//   lock        channel locked
//   err         sticky error
// ---------------------------------------------------------------------------
module clk_period_chk
   import clk_div_mon_pkg::*;
#(
   parameter int DIV      = 10,
   parameter int CNT_W    = 8,
   parameter int LOCK_CNT = 4
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             mon_clk,
   input  logic             clr_err,
   output logic [CNT_W-1:0] period,
   output logic             meas_valid,
   output logic             lock,
   output logic             err
);

   localparam int                GOOD_W   = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0]  DIV_V    = CNT_W'(DIV);
   localparam logic [CNT_W-1:0]  HALF_V   = CNT_W'(DIV / 2);
   localparam logic [CNT_W-1:0]  ONE_V    = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
   localparam logic [GOOD_W-1:0] LOCK_V   = GOOD_W'(LOCK_CNT);

   chk_state_t        state_q, state_d;
   logic              s_q, s_d;
   logic              p_q, p_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  hi_q, hi_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic              valid_q, valid_d;
   logic              lock_q, lock_d;
   logic              err_q, err_d;
   logic [GOOD_W-1:0] good_q, good_d;
   logic [GOOD_W-1:0] good_inc;
   logic              rise;
   logic              good_meas;

   // Edge detect and measurement FSM next-state logic. The monitored clock
   // needs no synchronizer because it is already in the clk_in domain.
   // hi only counts while the sampled clock is high; once it falls it stays
   // low until the next rise, so hi holds the high time at the next rise.
   // A counter that would reach all-ones without a rise means a stuck clock:
   // report it as an all-ones period and drop back to IDLE to re-arm.
   always_comb begin
      s_d       = mon_clk;
      p_d       = s_q;
      rise      = s_q & ~p_q;
      good_meas = (cnt_q == DIV_V) && (hi_q == HALF_V);
      good_inc  = (good_q == LOCK_V) ? good_q : good_q + GOOD_W'(1);
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      period_d  = period_q;
      valid_d   = 1'b0;
      lock_d    = lock_q;
      err_d     = err_q & ~clr_err;
      good_d    = good_q;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = MEAS;
               cnt_d   = ONE_V;
               hi_d    = ONE_V;
            end
         end
         MEAS: begin
            if (rise) begin
               period_d = cnt_q;
               valid_d  = 1'b1;
               cnt_d    = ONE_V;
               hi_d     = ONE_V;
               if (good_meas) begin
                  good_d = good_inc;
                  lock_d = (good_inc == LOCK_V);
               end else begin
                  err_d  = 1'b1;
                  good_d = '0;
                  lock_d = 1'b0;
               end
            end else if (cnt_q == CNT_LAST) begin
               period_d = '1;
               valid_d  = 1'b1;
               err_d    = 1'b1;
               lock_d   = 1'b0;
               good_d   = '0;
               cnt_d    = '0;
               hi_d     = '0;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + ONE_V;
               if (s_q) begin
                  hi_d = hi_q + ONE_V;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // All channel state, including the registered outputs, in one flop bank
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         s_q      <= 1'b0;
         p_q      <= 1'b0;
         cnt_q    <= '0;
         hi_q     <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         lock_q   <= 1'b0;
         err_q    <= 1'b0;
         good_q   <= '0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         p_q      <= p_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         lock_q   <= lock_d;
         err_q    <= err_d;
         good_q   <= good_d;
      end
   end

   assign period     = period_q;
   assign meas_valid = valid_q;
   assign lock       = lock_q;
   assign err        = err_q;

endmodule

// File: rtl/clk_div_monitor.sv
// ---------------------------------------------------------------------------
// clk_div_monitor
// Consumer-side checker for the freq_div outputs. One independent period
// checker per divided clock; this level only gathers their outputs.
// Ports:
//   CLK_in      reference clock
//   RST_n       asynchronous active-low reset
//   CLK_50      monitored clock, channel 0
//   CLK_10      monitored clock, channel 1
//   CLK_1       monitored clock, channel 2
//   clr_err     clears all sticky error bits
//   period_50   last measured period, channel 0
//   period_10   last measured period, channel 1
//   period_1    last measured period, channel 2
//   meas_valid  per-channel period update strobe
//   lock        per-channel lock
//   err         per-channel sticky error
//   all_lock    every channel locked
// ---------------------------------------------------------------------------
module clk_div_monitor
   import clk_div_mon_pkg::*;
#(
   parameter int DIV_50   = DIV_50_DEF,
   parameter int DIV_10   = DIV_10_DEF,
   parameter int DIV_1    = DIV_1_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int LOCK_CNT = LOCK_CNT_DEF
) (
   input  logic             CLK_in,
   input  logic             RST_n,
   input  logic             CLK_50,
   input  logic             CLK_10,
   input  logic             CLK_1,
   input  logic             clr_err,
   output logic [CNT_W-1:0] period_50,
   output logic [CNT_W-1:0] period_10,
   output logic [CNT_W-1:0] period_1,
   output logic [2:0]       meas_valid,
   output logic [2:0]       lock,
   output logic [2:0]       err,
   output logic             all_lock
);

   logic [2:0] valid_w;
   logic [2:0] lock_w;
   logic [2:0] err_w;

   clk_period_chk #(.DIV(DIV_50), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) u_chk_50 (
      .clk_in     (CLK_in),
      .rst_n      (RST_n),
      .mon_clk    (CLK_50),
      .clr_err    (clr_err),
      .period     (period_50),
      .meas_valid (valid_w[0]),
      .lock       (lock_w[0]),
      .err        (err_w[0])
   );

   clk_period_chk #(.DIV(DIV_10), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) u_chk_10 (
      .clk_in     (CLK_in),
      .rst_n      (RST_n),
      .mon_clk    (CLK_10),
      .clr_err    (clr_err),
      .period     (period_10),
      .meas_valid (valid_w[1]),
      .lock       (lock_w[1]),
      .err        (err_w[1])
   );

   clk_period_chk #(.DIV(DIV_1), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) u_chk_1 (
      .clk_in     (CLK_in),
      .rst_n      (RST_n),
      .mon_clk    (CLK_1),
      .clr_err    (clr_err),
      .period     (period_1),
      .meas_valid (valid_w[2]),
      .lock       (lock_w[2]),
      .err        (err_w[2])
   );

   assign meas_valid = valid_w;
   assign lock       = lock_w;
   assign err        = err_w;
   assign all_lock   = &lock_w;

endmodule

// File: tb/tb_clk_div_monitor.sv
// ---------------------------------------------------------------------------
// tb_clk_div_monitor
// Directed bench for clk_div_monitor. Inputs change 1 time unit after each
// CLK_in rising edge and outputs are read at that same point, so a level
// driven in cycle t is sampled at edge t, a rise is acted on one edge later,
// and its result is readable after the following cycle() call.
// ---------------------------------------------------------------------------
module tb_clk_div_monitor;

   logic       CLK_in = 1'b0;
   logic       RST_n;
   logic       CLK_50;
   logic       CLK_10;
   logic       CLK_1;
   logic       clr_err;
   logic [7:0] period_50;
   logic [7:0] period_10;
   logic [7:0] period_1;
   logic [2:0] meas_valid;
   logic [2:0] lock;
   logic [2:0] err;
   logic       all_lock;

   int tests_run    = 0;
   int tests_failed = 0;

   clk_div_monitor dut (
      .CLK_in     (CLK_in),
      .RST_n      (RST_n),
      .CLK_50     (CLK_50),
      .CLK_10     (CLK_10),
      .CLK_1      (CLK_1),
      .clr_err    (clr_err),
      .period_50  (period_50),
      .period_10  (period_10),
      .period_1   (period_1),
      .meas_valid (meas_valid),
      .lock       (lock),
      .err        (err),
      .all_lock   (all_lock)
   );

   // Reference clock, period 10
   always #5 CLK_in = ~CLK_in;

   // Advance one reference edge and settle just after it
   task automatic cycle();
      @(posedge CLK_in);
      #1;
   endtask

   // Hold reset for two edges with all monitored clocks low, then release
   task automatic apply_reset();
      RST_n   = 1'b0;
      CLK_50  = 1'b0;
      CLK_10  = 1'b0;
      CLK_1   = 1'b0;
      clr_err = 1'b0;
      cycle();
      cycle();
      RST_n = 1'b1;
      cycle();
   endtask

   task automatic set_ch(input int ch, input logic v);
      case (ch)
         0:       CLK_50 = v;
         1:       CLK_10 = v;
         default: CLK_1  = v;
      endcase
   endtask

   // One period on one channel: hi cycles high then lo cycles low
   task automatic drive_period(input int ch, input int hi, input int lo);
      for (int i = 0; i < hi; i++) begin
         set_ch(ch, 1'b1);
         cycle();
      end
      for (int i = 0; i < lo; i++) begin
         set_ch(ch, 1'b0);
         cycle();
      end
   endtask

   task automatic test_reset();
      RST_n   = 1'b0;
      CLK_50  = 1'b0;
      CLK_10  = 1'b0;
      CLK_1   = 1'b0;
      clr_err = 1'b0;
      cycle();
      cycle();
      tests_run++;
      if ({period_50, period_10, period_1} !== 24'h000000) begin
         tests_failed++;
         $display("[TB] FAIL reset_periods: got %h expected 000000", {period_50, period_10, period_1});
      end
      tests_run++;
      if ({meas_valid, lock, err} !== 9'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_flags: got %b expected 000000000", {meas_valid, lock, err});
      end
      tests_run++;
      if (all_lock !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_all_lock: got %b expected 0", all_lock);
      end
      RST_n = 1'b1;
      cycle();
   endtask

   task automatic test_ideal();
      int v0 = 0;
      int v1 = 0;
      int v2 = 0;
      apply_reset();
      for (int t = 0; t < 410; t++) begin
         CLK_50 = (t % 2) == 0;
         CLK_10 = (t % 10) < 5;
         CLK_1  = (t % 100) < 50;
         cycle();
         v0 += int'(meas_valid[0]);
         v1 += int'(meas_valid[1]);
         v2 += int'(meas_valid[2]);
         if (t == 400) begin
            tests_run++;
            if (lock !== 3'b011) begin
               tests_failed++;
               $display("[TB] FAIL ideal_lock_before_5th_rise: got %b expected 011", lock);
            end
         end
         if (t == 401) begin
            tests_run++;
            if (lock !== 3'b111 || all_lock !== 1'b1) begin
               tests_failed++;
               $display("[TB] FAIL ideal_lock_after_5th_rise: got lock=%b all_lock=%b expected 111/1", lock, all_lock);
            end
         end
      end
      tests_run++;
      if ({period_50, period_10, period_1} !== {8'd2, 8'd10, 8'd100}) begin
         tests_failed++;
         $display("[TB] FAIL ideal_periods: got %0d/%0d/%0d expected 2/10/100", period_50, period_10, period_1);
      end
      tests_run++;
      if (err !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL ideal_err: got %b expected 000", err);
      end
      tests_run++;
      if (v0 != 204 || v1 != 40 || v2 != 4) begin
         tests_failed++;
         $display("[TB] FAIL ideal_valid_count: got %0d/%0d/%0d expected 204/40/4", v0, v1, v2);
      end
   endtask

   task automatic test_long_period();
      apply_reset();
      repeat (5) drive_period(1, 5, 5);
      tests_run++;
      if (lock[1] !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL long_prelock: got %b expected 1", lock[1]);
      end
      drive_period(1, 6, 6);
      drive_period(1, 5, 5);
      tests_run++;
      if (period_10 !== 8'd12 || err[1] !== 1'b1 || lock[1] !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL long_detect: got period=%0d err=%b lock=%b expected 12/1/0", period_10, err[1], lock[1]);
      end
      repeat (3) drive_period(1, 5, 5);
      tests_run++;
      if (lock[1] !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL long_relock_3good: got %b expected 0", lock[1]);
      end
      drive_period(1, 5, 5);
      tests_run++;
      if (lock[1] !== 1'b1 || err[1] !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL long_relock_4good: got lock=%b err=%b expected 1/1", lock[1], err[1]);
      end
   endtask

   task automatic test_high_time();
      apply_reset();
      repeat (5) drive_period(1, 5, 5);
      drive_period(1, 3, 7);
      drive_period(1, 5, 5);
      tests_run++;
      if (period_10 !== 8'd10 || err[1] !== 1'b1 || lock[1] !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL high_time: got period=%0d err=%b lock=%b expected 10/1/0", period_10, err[1], lock[1]);
      end
   endtask

   task automatic test_stuck();
      apply_reset();
      CLK_1 = 1'b1;
      cycle();
      CLK_1 = 1'b0;
      for (int k = 1; k <= 256; k++) begin
         cycle();
         if (k == 254) begin
            tests_run++;
            if (meas_valid[2] !== 1'b0 || period_1 !== 8'h00) begin
               tests_failed++;
               $display("[TB] FAIL stuck_early: got valid=%b period=%h expected 0/00", meas_valid[2], period_1);
            end
         end
         if (k == 255) begin
            tests_run++;
            if (meas_valid[2] !== 1'b1 || period_1 !== 8'hFF || err[2] !== 1'b1 || lock[2] !== 1'b0) begin
               tests_failed++;
               $display("[TB] FAIL stuck_report: got valid=%b period=%h err=%b lock=%b expected 1/ff/1/0", meas_valid[2], period_1, err[2], lock[2]);
            end
         end
         if (k == 256) begin
            tests_run++;
            if (meas_valid[2] !== 1'b0) begin
               tests_failed++;
               $display("[TB] FAIL stuck_pulse_width: got %b expected 0", meas_valid[2]);
            end
         end
      end
      drive_period(2, 50, 50);
      tests_run++;
      if (period_1 !== 8'hFF) begin
         tests_failed++;
         $display("[TB] FAIL stuck_rearm: got period=%h expected ff", period_1);
      end
      drive_period(2, 50, 50);
      tests_run++;
      if (period_1 !== 8'd100 || err[2] !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL stuck_recover: got period=%0d err=%b expected 100/1", period_1, err[2]);
      end
   endtask

   task automatic test_clr_err();
      apply_reset();
      repeat (3) drive_period(0, 1, 1);
      drive_period(0, 2, 2);
      tests_run++;
      if (err !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL clr_pre: got %b expected 000", err);
      end
      CLK_50 = 1'b1;
      cycle();
      CLK_50  = 1'b0;
      clr_err = 1'b1;
      cycle();
      clr_err = 1'b0;
      tests_run++;
      if (err !== 3'b001 || period_50 !== 8'd4) begin
         tests_failed++;
         $display("[TB] FAIL clr_same_cycle: got err=%b period=%0d expected 001/4", err, period_50);
      end
      cycle();
      tests_run++;
      if (err !== 3'b001) begin
         tests_failed++;
         $display("[TB] FAIL clr_sticky: got %b expected 001", err);
      end
      clr_err = 1'b1;
      cycle();
      clr_err = 1'b0;
      tests_run++;
      if (err !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL clr_alone: got %b expected 000", err);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int t = 0; t < 60; t++) begin
         CLK_50 = (t % 2) == 0;
         CLK_10 = (t % 10) < 5;
         CLK_1  = (t % 100) < 50;
         cycle();
      end
      tests_run++;
      if (lock[0] !== 1'b1 || period_10 !== 8'd10) begin
         tests_failed++;
         $display("[TB] FAIL mid_prereset: got lock0=%b period10=%0d expected 1/10", lock[0], period_10);
      end
      #2;
      RST_n = 1'b0;
      #1;
      tests_run++;
      if ({period_50, period_10, period_1, meas_valid, lock, err, all_lock} !== 34'b0) begin
         tests_failed++;
         $display("[TB] FAIL mid_async_clear: got %h expected 0", {period_50, period_10, period_1, meas_valid, lock, err, all_lock});
      end
      CLK_50 = 1'b0;
      CLK_10 = 1'b0;
      CLK_1  = 1'b0;
      cycle();
      cycle();
      RST_n = 1'b1;
      for (int t = 0; t < 13; t++) begin
         CLK_50 = (t % 2) == 0;
         CLK_10 = (t % 10) < 5;
         CLK_1  = (t % 100) < 50;
         cycle();
         if (t == 1) begin
            tests_run++;
            if (meas_valid !== 3'b000) begin
               tests_failed++;
               $display("[TB] FAIL mid_first_rise: got %b expected 000", meas_valid);
            end
         end
         if (t == 3) begin
            tests_run++;
            if (meas_valid !== 3'b001) begin
               tests_failed++;
               $display("[TB] FAIL mid_second_rise_ch0: got %b expected 001", meas_valid);
            end
         end
         if (t == 11) begin
            tests_run++;
            if (meas_valid !== 3'b011) begin
               tests_failed++;
               $display("[TB] FAIL mid_second_rise_ch1: got %b expected 011", meas_valid);
            end
         end
      end
   endtask

   // Scenarios run back to back; each one starts from its own reset
   initial begin
      test_reset();
      test_ideal();
      test_long_period();
      test_high_time();
      test_stuck();
      test_clr_err();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
